// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: command encodings, flag
// positions, the status register type and the multiplier FSM states.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] status_t;

  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_state_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for WIDTH
// cycles, low WIDTH bits of the product presented with a one-cycle done pulse.
module alu_iter_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t       state, state_nx;
  logic [WIDTH-1:0] mcand, mplr, acc;
  logic [CW-1:0]    count;
  logic             last;

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state == MUL_RUN);
  // Product includes the bit being processed this cycle, so the caller can
  // capture it on the same edge that ends the run.
  assign product = acc + (mplr[0] ? mcand : '0);

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      MUL_IDLE: if (start) state_nx = MUL_RUN;
      MUL_RUN: begin
        if (last) begin
          done     = 1'b1;
          state_nx = MUL_IDLE;
        end
      end
      default: state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (state == MUL_IDLE && start) begin
        mcand <= a;
        mplr  <= b;
        acc   <= '0;
        count <= '0;
      end else if (state == MUL_RUN) begin
        acc   <= product;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes, internal NZCV
// status register and an optional iterative multiply.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic             busy
);

  status_t          status_q;
  logic             accept, is_mul, mul_start, mul_done, mul_s;
  logic [WIDTH-1:0] mul_product, alu_r;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, arith, is_sub, known, cin;

  assign cin       = status_q[FLAG_C];
  assign status    = status_q;
  assign in_ready  = !busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (MUL_EN != 0) && (cmd == CMD_MUL);
  assign mul_start = accept && is_mul;

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (val1),
    .b      (val2),
    .done   (mul_done),
    .busy   (busy),
    .product(mul_product)
  );

  always_comb begin
    sum    = '0;
    alu_r  = '0;
    alu_c  = status_q[FLAG_C];
    alu_v  = status_q[FLAG_V];
    arith  = 1'b0;
    is_sub = 1'b0;
    known  = 1'b1;
    case (cmd)
      CMD_MOV: alu_r = val2;
      CMD_MVN: alu_r = ~val2;
      CMD_AND: alu_r = val1 & val2;
      CMD_ORR: alu_r = val1 | val2;
      CMD_EOR: alu_r = val1 ^ val2;
      CMD_ADD: begin
        sum   = {1'b0, val1} + {1'b0, val2};
        arith = 1'b1;
      end
      CMD_ADC: begin
        sum   = {1'b0, val1} + {1'b0, val2} + (WIDTH+1)'(cin);
        arith = 1'b1;
      end
      CMD_SUB: begin
        sum    = {1'b0, val1} + {1'b0, ~val2} + (WIDTH+1)'(1'b1);
        arith  = 1'b1;
        is_sub = 1'b1;
      end
      CMD_SBC: begin
        sum    = {1'b0, val1} + {1'b0, ~val2} + (WIDTH+1)'(cin);
        arith  = 1'b1;
        is_sub = 1'b1;
      end
      default: known = 1'b0;
    endcase
    if (arith) begin
      alu_r = sum[WIDTH-1:0];
      alu_c = sum[WIDTH];
      alu_v = ((val1[WIDTH-1] ^ val2[WIDTH-1]) == is_sub) &&
              (sum[WIDTH-1] != val1[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      status_q  <= '0;
      mul_s     <= 1'b0;
    end else if (mul_done) begin
      result    <= mul_product;
      out_valid <= 1'b1;
      if (mul_s) begin
        status_q[FLAG_N] <= mul_product[WIDTH-1];
        status_q[FLAG_Z] <= (mul_product == '0);
      end
    end else if (accept) begin
      if (is_mul) begin
        // Accepting a MUL consumes any pending result; output refills on done.
        out_valid <= 1'b0;
        mul_s     <= s_bit;
      end else begin
        result    <= alu_r;
        out_valid <= 1'b1;
        if (s_bit && known) begin
          status_q[FLAG_N] <= alu_r[WIDTH-1];
          status_q[FLAG_Z] <= (alu_r == '0);
          if (arith) begin
            status_q[FLAG_C] <= alu_c;
            status_q[FLAG_V] <= alu_v;
          end
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
